// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding,
// requester port indices and a word-offset helper.
package dmem_pkg;

    // Arbiter FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    // Requester port indices
    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    // Word offset of a byte address into a 256-word memory
    function automatic logic [7:0] word_off(input logic [31:0] byte_addr);
        return byte_addr[9:2];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way request picker. Round-robin on contention (grant the port that
// was not granted last), or fixed priority to port 0 when fixed_prio is set.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    // One-hot grant; a lone request always wins regardless of history
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (fixed_prio || last) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data memory between the CPU load/store port (0) and
// a debug/loader port (1). One word access per transaction, three cycles:
// IDLE (arbitrate and register memory controls), SERVE (memory sees stable
// registered controls), ACK (one-cycle ack with registered read data).
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 256,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [2*ADDR_W-1:0]   addr_i,
    input  logic [2*DATA_W-1:0]   wdata_i,
    output logic [1:0]            ack_o,
    output logic                  err_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    // First byte address past the implemented memory
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * MEM_WORDS);

    logic [1:0]        state;
    logic              owner;
    logic              last;
    logic              we_q;
    logic              illegal_q;

    logic [1:0]        gnt;
    logic              win;
    logic              sel_we;
    logic              sel_illegal;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_arb (
        .req        (req_i),
        .last       (last),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt        (gnt)
    );

    // Select the winning port's attributes and classify its address
    always_comb begin
        win         = gnt[PORT_DBG];
        sel_addr    = win ? addr_i[PORT_DBG*ADDR_W +: ADDR_W] : addr_i[PORT_CPU*ADDR_W +: ADDR_W];
        sel_wdata   = win ? wdata_i[PORT_DBG*DATA_W +: DATA_W] : wdata_i[PORT_CPU*DATA_W +: DATA_W];
        sel_we      = win ? we_i[PORT_DBG] : we_i[PORT_CPU];
        sel_illegal = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= ADDR_LIMIT);
    end

    // Transaction FSM; memory controls come straight from these registers so
    // the memory write path never sees combinational glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;      // port 0 preferred on the first tie
            we_q        <= 1'b0;
            illegal_q   <= 1'b0;
            ack_o       <= 2'b00;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_i != 2'b00) begin
                        owner       <= win;
                        last        <= win;
                        we_q        <= sel_we;
                        illegal_q   <= sel_illegal;
                        mem_addr_o  <= sel_addr;
                        mem_wdata_o <= sel_wdata;
                        mem_we_o    <= sel_we && !sel_illegal;
                        state       <= ST_SERVE;
                    end else begin
                        mem_we_o <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    // Writes leave the previous read word on rdata_o
                    if (!we_q) begin
                        rdata_o <= illegal_q ? '0 : mem_rdata_i;
                    end
                    mem_we_o <= 1'b0;
                    ack_o    <= owner ? 2'b10 : 2'b01;
                    err_o    <= illegal_q;
                    state    <= ST_ACK;
                end
                ST_ACK: begin
                    ack_o <= 2'b00;
                    err_o <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    ack_o    <= 2'b00;
                    err_o    <= 1'b0;
                    mem_we_o <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
